// File: rtl/mant_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mant_mul_seq_if
// Description : Handshake bundle for the sequential 24x24 mantissa multiplier.
//               Upstream operand channel, flush, downstream product channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface mant_mul_seq_if;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_mant_a;
  logic [23:0] i_mant_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [47:0] o_product;
  logic        o_busy;

  // Multiplier side
  modport slave (
    input  i_valid, i_mant_a, i_mant_b, i_flush, i_ready,
    output o_ready, o_valid, o_product, o_busy
  );

  // Driver / consumer side
  modport master (
    output i_valid, i_mant_a, i_mant_b, i_flush, i_ready,
    input  o_ready, o_valid, o_product, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/mant_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : mant_mul_seq (with helper add_33bits)
// Description : Shift-and-add 24x24 unsigned mantissa multiplier. One 33-bit
//               adder is reused over 24 iterations to build the 48-bit product.
// Revision    : 1.0 - initial release
// ============================================================================

// 33-bit ripple adder shared by every multiply iteration
module add_33bits (
  input  wire logic [32:0] i_data_one,
  input  wire logic [32:0] i_data_two,
  input  wire logic        i_carry,
  output logic      [32:0] o_data,
  output logic             o_carry
);
  assign {o_carry, o_data} = {1'b0, i_data_one} + {1'b0, i_data_two} + {33'd0, i_carry};
endmodule

module mant_mul_seq (
  input  wire logic   i_clk,
  input  wire logic   i_rst_n,
  mant_mul_seq_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] a_q, a_d;
  // Upper partial product. Its 25th bit is provably always zero (the sum of
  // two 24-bit values shifted right by one fits in 24 bits), so it is not kept.
  logic [23:0] hi_q, hi_d;
  logic [23:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [47:0] product_q, product_d;

  logic [32:0] add_one;
  logic [32:0] add_two;
  logic [32:0] add_sum;
  logic        add_cout;
  logic [24:0] sum;
  logic        unused_add_bits;

  // Partial product plus multiplicand when the current multiplier bit is set
  assign add_one = {9'd0, hi_q};
  assign add_two = lo_q[0] ? {9'd0, a_q} : 33'd0;

  add_33bits u_add (
    .i_data_one (add_one),
    .i_data_two (add_two),
    .i_carry    (1'b0),
    .o_data     (add_sum),
    .o_carry    (add_cout)
  );

  assign sum             = add_sum[24:0];
  assign unused_add_bits = ^{add_sum[32:25], add_cout};

  // Next-state, datapath update and product capture
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_mant_a;
          hi_d    = 24'd0;
          lo_d    = bus.i_mant_b;
          cnt_d   = 5'd0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // Right shift of {sum, lo}: the consumed multiplier bit falls off
        hi_d  = sum[24:1];
        lo_d  = {sum[0], lo_q[23:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d   = ST_DONE;
          product_d = {sum, lo_q[23:1]};
        end
      end
      ST_DONE: begin
        if (bus.i_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over acceptance, iteration and the output handshake
    if (bus.i_flush) begin
      state_d   = ST_IDLE;
      product_d = product_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= 24'd0;
      hi_q      <= 24'd0;
      lo_q      <= 24'd0;
      cnt_q     <= 5'd0;
      product_q <= 48'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.o_ready   = (state_q == ST_IDLE);
  assign bus.o_busy    = (state_q == ST_CALC);
  assign bus.o_valid   = (state_q == ST_DONE);
  assign bus.o_product = product_q;
endmodule
`default_nettype wire

// File: tb/tb_mant_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mant_mul_seq
// Description : Directed scoreboard bench for mant_mul_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mant_mul_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [47:0] exp_q[$];

  mant_mul_seq_if bus ();

  mant_mul_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted product is compared with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_product: got 0x%0h expected none", bus.o_product);
      end else begin
        check("product", {16'd0, bus.o_product}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Present an operand pair for one accepting edge; optionally record the result
  task automatic issue(input logic [23:0] a, input logic [23:0] b, input bit push);
    bus.i_valid  = 1'b1;
    bus.i_mant_a = a;
    bus.i_mant_b = b;
    @(posedge clk); #1;
    bus.i_valid  = 1'b0;
    if (push) exp_q.push_back(48'(a) * 48'(b));
  endtask

  // Wait for o_valid, counting latency and busy cycles; optionally abuse inputs
  task automatic wait_done(input bit abuse, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!bus.o_valid && lat < 100) begin
      if (bus.o_busy) busy_cnt++;
      if (abuse) begin
        bus.i_valid  = (lat < 20) ? lat[0] : 1'b0;
        bus.i_mant_a = 24'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no o_valid expected o_valid within 100 cycles");
    end
  endtask

  int lat, busy_cnt;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_mant_a = 24'd0;
    bus.i_mant_b = 24'd0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    #23;
    check("reset_ready", 64'(bus.o_ready), 64'd1);
    check("reset_valid", 64'(bus.o_valid), 64'd0);
    check("reset_busy", 64'(bus.o_busy), 64'd0);
    check("reset_product", 64'(bus.o_product), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-scale operands: latency and busy window
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b1);
    exp_q[exp_q.size()-1] = 48'hFFFFFE000001;
    wait_done(1'b0, lat, busy_cnt);
    check("latency", 64'(lat), 64'd24);
    check("busy_cycles", 64'(busy_cnt), 64'd24);
    @(posedge clk); #1;
    check("ready_after_done", 64'(bus.o_ready), 64'd1);

    // Assorted directed products (expectations from hand-computed table)
    begin
      logic [23:0] ta[4] = '{24'hC00000, 24'h800000, 24'hFFFFFF, 24'h000000};
      logic [23:0] tb[4] = '{24'hA00000, 24'h800000, 24'h800000, 24'h123456};
      logic [47:0] tp[4] = '{48'h780000000000, 48'h400000000000, 48'h7FFFFF800000, 48'h0};
      for (int i = 0; i < 4; i++) begin
        issue(ta[i], tb[i], 1'b0);
        exp_q.push_back(tp[i]);
        wait_done(1'b0, lat, busy_cnt);
        check("latency_vec", 64'(lat), 64'd24);
        @(posedge clk); #1;
      end
    end

    // Backpressure: product must hold while downstream stalls
    bus.i_ready = 1'b0;
    issue(24'hC00000, 24'hA00000, 1'b0);
    exp_q.push_back(48'h780000000000);
    wait_done(1'b0, lat, busy_cnt);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(bus.o_valid), 64'd1);
      check("bp_product", 64'(bus.o_product), 64'h780000000000);
      check("bp_ready", 64'(bus.o_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 64'(bus.o_ready), 64'd1);
    check("bp_release_valid", 64'(bus.o_valid), 64'd0);

    // Operand and valid abuse during CALC
    issue(24'hFFFFFF, 24'h800000, 1'b0);
    exp_q.push_back(48'h7FFFFF800000);
    wait_done(1'b1, lat, busy_cnt);
    check("abuse_latency", 64'(lat), 64'd24);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abuse_no_second", 64'(bus.o_ready), 64'd1);

    // Flush on the 10th CALC cycle, then an immediate fresh operation
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("flush_pre_busy", 64'(bus.o_busy), 64'd1);
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    check("flush_ready", 64'(bus.o_ready), 64'd1);
    check("flush_valid", 64'(bus.o_valid), 64'd0);
    issue(24'h800000, 24'h800000, 1'b0);
    exp_q.push_back(48'h400000000000);
    wait_done(1'b0, lat, busy_cnt);
    check("post_flush_latency", 64'(lat), 64'd24);
    @(posedge clk); #1;

    // Flush coincident with i_valid in IDLE: not accepted
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    check("flush_idle_busy", 64'(bus.o_busy), 64'd0);
    check("flush_idle_ready", 64'(bus.o_ready), 64'd1);

    // Flush in DONE with downstream stalled: result dropped
    bus.i_ready = 1'b0;
    issue(24'hC00000, 24'hA00000, 1'b0);
    wait_done(1'b0, lat, busy_cnt);
    bus.i_flush = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    check("flush_done_ready", 64'(bus.o_ready), 64'd1);
    check("flush_done_valid", 64'(bus.o_valid), 64'd0);

    // Flush coincident with i_ready in DONE
    issue(24'h800000, 24'h800000, 1'b0);
    exp_q.push_back(48'h400000000000);
    wait_done(1'b0, lat, busy_cnt);
    bus.i_flush = 1'b1;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_flush = 1'b0;
    check("flush_rdy_ready", 64'(bus.o_ready), 64'd1);

    // Asynchronous reset mid-CALC, off the clock edge
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_product", 64'(bus.o_product), 64'd0);
    check("areset_ready", 64'(bus.o_ready), 64'd1);
    check("areset_busy", 64'(bus.o_busy), 64'd0);
    #7;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(24'hC00000, 24'hA00000, 1'b0);
    exp_q.push_back(48'h780000000000);
    wait_done(1'b0, lat, busy_cnt);
    check("post_reset_latency", 64'(lat), 64'd24);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mant_mul_seq.md
# mant_mul_seq

Sequential controller for the 24-bit mantissa multiply of the single-precision floating-point multiplier. It time-shares one `add_33bits` instance over 24 shift-and-add iterations to form the 48-bit unsigned product of two mantissas, hidden bit included. It sits between operand unpacking (upstream) and normalize/round (downstream), with a valid/ready handshake on each side.

## Interface
Parameters:
- none (mantissa width fixed at 24, product 48, adder 33)

Ports:
- `i_clk`  input  1  single clock, rising edge
- `i_rst_n`  input  1  reset, asynchronous, active-low
- `i_valid`  input  1  upstream operands valid
- `o_ready`  output  1  block can accept operands (high only in IDLE)
- `i_mant_a`  input  24  multiplicand mantissa, unsigned
- `i_mant_b`  input  24  multiplier mantissa, unsigned
- `i_flush`  input  1  synchronous abort, returns to IDLE
- `o_valid`  output  1  product valid (DONE state)
- `i_ready`  input  1  downstream accepts product
- `o_product`  output  48  unsigned product a*b
- `o_busy`  output  1  high in CALC

## Operation
- FSM states: IDLE, CALC, DONE. Reset state IDLE.
- IDLE:
  - `o_ready`=1.
  - On `i_valid`&`o_ready`: latch A<=`i_mant_a`, HI<=0 (25 bits), LO<=`i_mant_b`, CNT<=0, go to CALC.
- CALC, one iteration per cycle:
  - Adder inputs: `i_data_one`={9'b0,HI[23:0]}, `i_data_two`= LO[0] ? {9'b0,A} : 33'b0, `i_carry`=0.
  - Sum S[24:0] = adder `o_data`[24:0]. Bits [32:25] are always 0; adder `o_carry` is unused.
  - Update {HI,LO} <= {1'b0, S, LO[23:1]}. This is a right shift of the 49-bit concatenation {S, LO}.
  - CNT increments. When CNT==23 on this edge, go to DONE. Exactly 24 iterations.
- DONE:
  - `o_valid`=1, `o_product`={HI[23:0],LO}.
  - On `i_valid`… not sampled. On `i_ready`=1, go to IDLE.
- `o_product` is registered and holds its last value in IDLE/CALC. It is only guaranteed meaningful while `o_valid`=1.
- `i_flush`=1 in any state: next state IDLE, `o_valid` drops next cycle. Flush has priority over acceptance and over the DONE handshake. The product register is not cleared.
- Operand changes on `i_mant_*` after acceptance have no effect.
- `i_valid` is ignored outside IDLE. Upstream must hold operands until the handshake.
- Reset while `i_rst_n` low, from any state:
  - state IDLE, HI/LO/A/CNT=0, `o_product`=0.
  - `o_valid`=0, `o_busy`=0, `o_ready`=1 (decoded from IDLE).
- Zero operands take the full 24 iterations. There is no early termination.

## Timing
- Acceptance edge T0 → CALC on T1..T24 edges (24 iterations). `o_valid` is high from after T24.
- Latency is 24 cycles from acceptance to `o_valid`.
- With `i_ready` held high, DONE lasts 1 cycle and `o_ready` returns the following cycle. Minimum initiation interval is 26 cycles.
- `o_busy`=1 exactly during the 24 CALC cycles.
- `o_ready`, `o_valid` and `o_busy` decode from state registers only, with no combinational path from inputs.
- The single adder path is the critical path: 33-bit ripple through `add_33bits`, plus mux and register setup.

## Test plan
- Reset then a*b = 0xFFFFFF*0xFFFFFF, `i_ready`=1 → `o_valid` 24 cycles after acceptance, `o_product`=0xFFFFFE000001, `o_busy` high exactly 24 cycles.
- 0xC00000*0xA00000 → 0x780000000000. 0x800000*0x800000 → 0x400000000000. 0xFFFFFF*0x800000 → 0x7FFFFF800000. 0*0x123456 → 0.
- Backpressure: finish 0xC00000*0xA00000 with `i_ready`=0 for 5 cycles → `o_valid` and `o_product` stable for all 5, `o_ready`=0. IDLE follows one cycle after `i_ready` rises.
- Operand/valid abuse: change `i_mant_a` and toggle `i_valid` during CALC → result unchanged, no second acceptance.
- Flush at 10th CALC cycle → IDLE next cycle, `o_valid` never asserts. An immediate new pair 0x800000*0x800000 then yields 0x400000000000.
- Flush coincident with `i_valid` in IDLE → not accepted. Flush coincident with `i_ready` in DONE → IDLE.
- Async reset pulsed mid-CALC (not clock-aligned) → outputs go to their reset values immediately: `o_product`=0, `o_ready`=1. Next operation completes correctly.
